uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered UART transmitter for the rv32i_soc peripheral set, the transmit end that pairs with the SoC's UART receive path on `o_uart_tx`. It accepts bytes from a simple write-strobe interface into a small synchronous FIFO. It serialises each byte as 8N1 (one start bit, 8 data bits LSB-first, one stop bit) at a runtime-programmable bit period. Bus-side register decoding belongs to the wrapping peripheral; this block holds the FIFO, the baud counter and the frame FSM.

## Interface
- `FIFO_DEPTH`, default 8: byte entries; power of two, ≥2.
- `DIV_W`, default 16: width of the baud divisor.
- `clk` input 1: single clock.
- `reset` input 1: asynchronous, active-high.
- `i_baud_div` input DIV_W: bit period is i_baud_div+1 clk cycles.
- `i_wr_en` input 1: push strobe.
- `i_wr_data` input 8: byte to push.
- `o_full` output 1: FIFO holds FIFO_DEPTH entries.
- `o_empty` output 1: FIFO holds zero entries.
- `o_count` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `o_overflow` output 1: one-cycle pulse when a push is rejected.
- `o_busy` output 1: FSM not IDLE.
- `o_uart_tx` output 1: serial line, registered, idle high.

## Operation
- Reset values: `o_uart_tx`=1, `o_busy`=0, `o_empty`=1, `o_full`=0, `o_count`=0, `o_overflow`=0. FSM=IDLE, FIFO pointers=0.
- Push: sampled at a clk edge when `i_wr_en`=1 and `o_full`=0.
  - `o_full` is the registered flag. A push while full is rejected even if a pop occurs the same cycle. `o_overflow` then pulses high for the following cycle and FIFO contents are unchanged.
- Push and pop in the same cycle (not full): count unchanged, both take effect.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into the shift register, latch `i_baud_div` into the divisor register, go to START. `o_uart_tx` is driven 0 from the same edge.
  - START: hold 0 for one bit period, then go to DATA with bit index 0.
  - DATA: drive shift[0] each bit period, shift right, and increment the index. After bit 7's period, go to STOP.
  - STOP: drive 1 for one bit period. On its last cycle, if the FIFO is non-empty, pop and go directly to START, with no idle gap and the divisor re-latched. Otherwise go to IDLE.
- Baud counter: counts 0..latched_div and resets at each bit boundary. Changing `i_baud_div` mid-frame has no effect until the next frame start.
- `i_baud_div`=0 gives 1 cycle per bit (10-cycle frame).
- Reset asserted mid-frame: line returns high asynchronously, and the FIFO and partial frame are discarded.

## Timing
- A push sampled at edge N into an empty FIFO with the FSM in IDLE: `o_empty` falls after N. The pop happens at N+1 and `o_uart_tx` falls after N+1.
- Frame length is exactly 10×(div+1) cycles. Back-to-back frames are contiguous.
- `o_count`, `o_full` and `o_empty` update on the edge of the push or pop.
- `o_busy` rises with START and falls on the edge leaving STOP to IDLE.

## Structure
- Shared package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e`
  - `UART_DATA_W`=8
  - `UART_FRAME_BITS`=10
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH), reusable by the receiver:
  - Ports: push/pop/data/full/empty/count.
  - Async active-high reset, no fall-through.
- The top holds the FSM, baud counter, bit index, shift register and overflow pulse.

## Test plan
- Reset: hold `reset` 3 cycles → all outputs at their reset values. Assert `reset` mid-frame of byte 0x00 → `o_uart_tx`=1 immediately, `o_count`=0.
- Single byte: `i_baud_div`=3, push 0xA5 → line low 1 cycle after the push edge. Bits each 4 cycles: 0, then 1,0,1,0,0,1,0,1, then 1. `o_busy` is high for exactly 40 cycles.
- Back-to-back: div=1, push 0x01, 0x80, 0xFF on consecutive cycles → 60 contiguous cycles of framing, no idle cycle between stop and start, then `o_empty`=1.
- Overflow: div=100, `i_wr_en` high for 10 consecutive cycles (bytes 0..9) → byte 0 popped, 8 stored (`o_count`=8, `o_full`=1), byte 9 rejected. `o_overflow` is a single 1-cycle pulse. Transmitted sequence is 0..8.
- Divisor change: div=2, push 0x55, change div to 0 during DATA → frame keeps 3-cycle bits (30 cycles). The next pushed byte uses 1-cycle bits.
- Minimum divisor: div=0, push 0x3C → 10-cycle frame: 0,0,0,1,1,1,1,0,0,1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   uart_tx_state_e  - transmit frame FSM states
//   UART_DATA_W      - payload bits per frame
//   UART_FRAME_BITS  - start + data + stop bits per frame (8N1)
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;

   localparam int UART_DATA_W     = 8;
   localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty/count flags.
// A word pushed into an empty FIFO only becomes visible once `empty`
// has dropped on the following edge (no fall-through). The head word is
// always presented on pop_data, so a consumer can take it on the same
// edge that pops it.
//   clk, reset        : clock, asynchronous active-high reset
//   push, push_data   : write strobe and word (ignored while full)
//   pop, pop_data     : read strobe (ignored while empty) and head word
//   full, empty, count: registered occupancy status
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             full_reg;
   logic             empty_reg;
   logic             do_push;
   logic             do_pop;

   // Qualify strobes with the registered flags: a push while full is
   // dropped even if a pop frees a slot on the same edge.
   assign do_push = push & ~full_reg;
   assign do_pop  = pop & ~empty_reg;

   // Head word read combinationally so the consumer can load it on the pop edge.
   assign pop_data = mem[rd_ptr_reg];
   assign full     = full_reg;
   assign empty    = empty_reg;
   assign count    = count_reg;

   always_comb begin
      count_next = count_reg;
      if (do_push && !do_pop) begin
         count_next = count_reg + 1'b1;
      end else if (!do_push && do_pop) begin
         count_next = count_reg - 1'b1;
      end
   end

   // Storage carries no reset; pointers and flags define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
      end else begin
         // DEPTH is a power of two, so the pointers wrap naturally.
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
         full_reg  <= (count_next == CNT_W'(DEPTH));
         empty_reg <= (count_next == '0);
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Bytes pushed through i_wr_en/i_wr_data are queued in a sync_fifo and
// sent LSB-first with one start and one stop bit. Each bit lasts
// latched_div+1 clocks; the divisor is sampled from i_baud_div whenever
// a frame starts, so changes mid-frame only affect later frames.
//   clk, reset          : clock, asynchronous active-high reset
//   i_baud_div          : bit period minus one, in clk cycles
//   i_wr_en, i_wr_data  : push strobe and byte
//   o_full, o_empty,
//   o_count             : FIFO status
//   o_overflow          : one-cycle pulse after a rejected push
//   o_busy              : a frame is in progress
//   o_uart_tx           : registered serial line, idle high
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DIV_W-1:0]            i_baud_div,
   input  logic                        i_wr_en,
   input  logic [7:0]                  i_wr_data,
   output logic                        o_full,
   output logic                        o_empty,
   output logic [$clog2(FIFO_DEPTH):0] o_count,
   output logic                        o_overflow,
   output logic                        o_busy,
   output logic                        o_uart_tx
);

   uart_tx_state_e         state_reg;
   logic [DIV_W-1:0]       div_reg;
   logic [DIV_W-1:0]       baud_cnt_reg;
   logic [2:0]             bit_idx_reg;
   logic [UART_DATA_W-1:0] shift_reg;
   logic [UART_DATA_W-1:0] head;
   logic                   tx_reg;
   logic                   busy_reg;
   logic                   overflow_reg;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   bit_end;
   logic                   pop;

   assign bit_end = (baud_cnt_reg == div_reg);

   // Pop from IDLE, or on the last cycle of STOP so the next start bit
   // follows the stop bit with no idle gap.
   assign pop = ~fifo_empty &
                ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));

   sync_fifo #(
      .WIDTH (UART_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (i_wr_en),
      .push_data (i_wr_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (o_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         div_reg      <= '0;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
         busy_reg     <= 1'b0;
      end else begin
         baud_cnt_reg <= bit_end ? '0 : baud_cnt_reg + 1'b1;
         unique case (state_reg)
            IDLE: begin
               baud_cnt_reg <= '0;
               if (pop) begin
                  shift_reg <= head;
                  div_reg   <= i_baud_div;
                  tx_reg    <= 1'b0;
                  busy_reg  <= 1'b1;
                  state_reg <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  tx_reg      <= shift_reg[0];
                  shift_reg   <= shift_reg >> 1;
                  bit_idx_reg <= '0;
                  state_reg   <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx_reg == 3'd7) begin
                     tx_reg    <= 1'b1;
                     state_reg <= STOP;
                  end else begin
                     tx_reg      <= shift_reg[0];
                     shift_reg   <= shift_reg >> 1;
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                  end
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (pop) begin
                     shift_reg <= head;
                     div_reg   <= i_baud_div;
                     tx_reg    <= 1'b0;
                     state_reg <= START;
                  end else begin
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_reg <= 1'b0;
      end else begin
         overflow_reg <= i_wr_en & fifo_full;
      end
   end

   assign o_full     = fifo_full;
   assign o_empty    = fifo_empty;
   assign o_overflow = overflow_reg;
   assign o_busy     = busy_reg;
   assign o_uart_tx  = tx_reg;

endmodule
